// File: rtl/booth_wallace.sv
// Two-stage radix-4 Booth / Wallace-tree multiplier front end. It produces the
// sum and carry rows for a downstream 66-bit adder.
module booth_wallace (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_a_signed,
  input  logic        in_b_signed,
  input  logic [4:0]  in_tag,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [65:0] out_sum,
  output logic [65:0] out_carry,
  output logic [4:0]  out_tag
);

  logic        s1_valid_r;
  logic [32:0] s1_a_r;
  logic [32:0] s1_b_r;
  logic [4:0]  s1_tag_r;
  logic        s2_valid_r;
  logic [65:0] s2_sum_r;
  logic [65:0] s2_carry_r;
  logic [4:0]  s2_tag_r;

  logic        s1_advance_s;
  logic        take_s;
  logic [65:0] tree_sum_s;
  logic [65:0] tree_carry_s;

  logic [34:0] bx_s;
  logic [65:0] a66_s;
  logic [2:0]  trip_s;
  logic [65:0] mag_s;
  logic        neg_s;
  logic [65:0] maj_s;
  logic [65:0] rows_s [0:17];
  logic [65:0] nxt_s  [0:17];
  int          n_s;

  assign s1_advance_s = s1_valid_r & (~s2_valid_r | out_ready);
  assign in_ready     = rst_n & ~flush & (~s1_valid_r | s1_advance_s);
  assign take_s       = in_valid & in_ready;

  assign out_valid = s2_valid_r;
  assign out_sum   = s2_sum_r;
  assign out_carry = s2_carry_r;
  assign out_tag   = s2_tag_r;

  // Stage 1: capture the extended operands and tag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 33'd0;
      s1_b_r     <= 33'd0;
      s1_tag_r   <= 5'd0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (take_s) begin
      s1_valid_r <= 1'b1;
      s1_a_r     <= {in_a_signed & in_a[31], in_a};
      s1_b_r     <= {in_b_signed & in_b[31], in_b};
      s1_tag_r   <= in_tag;
    end else if (s1_advance_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Booth recoding of the multiplier and 3:2 reduction of all rows down to two
  always_comb begin
    bx_s   = {s1_b_r[32], s1_b_r, 1'b0};
    a66_s  = {{33{s1_a_r[32]}}, s1_a_r};
    trip_s = 3'd0;
    mag_s  = 66'd0;
    neg_s  = 1'b0;
    maj_s  = 66'd0;
    n_s    = 18;
    for (int r = 0; r < 18; r++) begin
      rows_s[r] = 66'd0;
      nxt_s[r]  = 66'd0;
    end
    // Row 17 collects the +1 of every negated partial product at weight 2i
    for (int i = 0; i < 17; i++) begin
      trip_s = bx_s[2*i +: 3];
      neg_s  = trip_s[2] & ~(trip_s[1] & trip_s[0]);
      case (trip_s)
        3'b001, 3'b010, 3'b101, 3'b110: mag_s = a66_s;
        3'b011, 3'b100:                 mag_s = {a66_s[64:0], 1'b0};
        default:                        mag_s = 66'd0;
      endcase
      rows_s[i]       = (neg_s ? ~mag_s : mag_s) << (2*i);
      rows_s[17][2*i] = neg_s;
    end
    // Six carry-save levels: 18 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows
    for (int l = 0; l < 6; l++) begin
      for (int r = 0; r < 18; r++) begin
        nxt_s[r] = 66'd0;
      end
      for (int g = 0; g < 6; g++) begin
        if (3*g + 2 < n_s) begin
          maj_s = (rows_s[3*g] & rows_s[3*g+1]) | (rows_s[3*g] & rows_s[3*g+2]) |
                  (rows_s[3*g+1] & rows_s[3*g+2]);
          nxt_s[2*g]   = rows_s[3*g] ^ rows_s[3*g+1] ^ rows_s[3*g+2];
          nxt_s[2*g+1] = {maj_s[64:0], 1'b0};
        end else if (3*g + 1 < n_s) begin
          nxt_s[2*g]   = rows_s[3*g];
          nxt_s[2*g+1] = rows_s[3*g+1];
        end else if (3*g < n_s) begin
          nxt_s[2*g]   = rows_s[3*g];
        end else begin
          nxt_s[2*g]   = 66'd0;
        end
      end
      n_s = (n_s / 3) * 2 + (n_s % 3);
      for (int r = 0; r < 18; r++) begin
        rows_s[r] = nxt_s[r];
      end
    end
    tree_sum_s   = rows_s[0];
    tree_carry_s = rows_s[1];
  end

  // Stage 2: output registers, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= 66'd0;
      s2_carry_r <= 66'd0;
      s2_tag_r   <= 5'd0;
    end else if (flush) begin
      s2_valid_r <= 1'b0;
    end else if (s1_advance_s) begin
      s2_valid_r <= 1'b1;
      s2_sum_r   <= tree_sum_s;
      s2_carry_r <= tree_carry_s;
      s2_tag_r   <= s1_tag_r;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

endmodule
